// File: rtl/uc_control.sv
// uc_control: sequencing control unit for the 8-bit microc datapath.
// Decodes the current opcode into datapath strobes, adds run / single-step /
// halt sequencing through a PC-enable output, and counts executed instructions.
module uc_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StStepWait,
        StHalt
    } state_t;

    localparam logic [5:0] OpcHalt = 6'b001000;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_step_req_q;
    logic [CNT_W-1:0] r_count;
    logic             w_step_edge;
    logic             w_exec;
    logic             w_is_halt;
    logic             w_count_sat;

    assign w_step_edge = step_req & ~r_step_req_q;
    assign w_count_sat = &r_count;
    assign halted      = (r_state == StHalt);
    assign instr_count = r_count;

    // State, step-request history and instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StBoot;
            r_step_req_q <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_step_req_q <= step_req;
            if (w_exec && !w_count_sat) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Mealy decode of the strobes plus next-state selection
    always_comb begin
        s_inc        = 1'b1;
        s_inm        = 1'b0;
        we3          = 1'b0;
        wez          = 1'b0;
        op           = 3'b000;
        pc_en        = 1'b0;
        w_is_halt    = (opcode == OpcHalt);
        w_exec       = (r_state == StRun) || ((r_state == StStepWait) && w_step_edge);
        w_state_next = r_state;

        if (w_exec) begin
            // HALT executes but must not advance the PC
            pc_en = ~w_is_halt;
            if (opcode[5]) begin
                op  = opcode[4:2];
                we3 = 1'b1;
                wez = 1'b1;
            end else if (opcode[5:2] == 4'b0001) begin
                we3   = 1'b1;
                s_inm = 1'b1;
            end else begin
                case (opcode)
                    6'b000001: s_inc = 1'b0;
                    6'b000010: s_inc = ~z;
                    6'b000011: s_inc = z;
                    default:   s_inc = 1'b1;
                endcase
            end
        end

        case (r_state)
            StBoot: begin
                w_state_next = step_mode ? StStepWait : StRun;
            end
            StRun, StStepWait: begin
                if (w_exec && w_is_halt) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = step_mode ? StStepWait : StRun;
                end
            end
            default: begin
                w_state_next = StHalt;
            end
        endcase
    end

endmodule

// File: tb/tb_uc_control.sv
// Scoreboard bench for uc_control: a driver applies stimulus each cycle and
// pushes the reference model's expectation; a monitor pops and compares.
module tb_uc_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        z;
    logic        step_mode;
    logic        step_req;
    logic        s_inc, s_inm, we3, wez, pc_en, halted;
    logic [2:0]  op;
    logic [15:0] instr_count;
    logic        s_inc4, s_inm4, we34, wez4, pc_en4, halted4;
    logic [2:0]  op4;
    logic [3:0]  instr_count4;

    uc_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .step_mode(step_mode), .step_req(step_req),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .pc_en(pc_en), .halted(halted), .instr_count(instr_count)
    );

    uc_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .step_mode(step_mode), .step_req(step_req),
        .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .op(op4),
        .pc_en(pc_en4), .halted(halted4), .instr_count(instr_count4)
    );

    typedef struct packed {
        logic [7:0]  dec;   // {s_inc, s_inm, we3, wez, op, pc_en}
        logic        hlt;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 boot, 1 running, 2 waiting for a step, 3 halted
    int   m_phase = 0;
    int   m_count = 0;
    logic m_prev  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] decode(input logic [5:0] opc, input logic zv);
        int v;
        v = int'(opc);
        if (v >= 32)           return {1'b1, 1'b0, 1'b1, 1'b1, opc[4:2], 1'b1};
        if (v >= 4 && v < 8)   return 8'b1110_0001;
        if (v == 1)            return 8'b0000_0001;
        if (v == 2)            return {~zv, 7'b000_0001};
        if (v == 3)            return {zv, 7'b000_0001};
        if (v == 8)            return 8'b1000_0000;
        return 8'b1000_0001;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.dec = 8'b1000_0000;
        e.hlt = 1'b0;
        e.c16 = 16'(m_count);
        e.c4  = (m_count > 15) ? 4'd15 : 4'(m_count);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_prev  = 1'b0;
    endtask

    // One clock cycle: drive, predict, push, then advance the model past the edge
    task automatic do_cycle(input logic rst_v, input logic [5:0] opc, input logic zv,
                            input logic md, input logic rq, input logic mid_rst);
        exp_t e;
        logic edge_v, exec;
        @(posedge clk);
        #1;
        reset = rst_v; opcode = opc; z = zv; step_mode = md; step_req = rq;
        if (!rst_v) model_reset();
        edge_v = rq & ~m_prev;
        exec   = rst_v && ((m_phase == 1) || (m_phase == 2 && edge_v));
        e      = idle_exp();
        e.hlt  = (m_phase == 3);
        if (exec) e.dec = decode(opc, zv);
        if (mid_rst) begin
            #1;
            check("pre_reset_we3", 32'(we3), 32'(e.dec[5]));
            #1;
            reset = 1'b0;
            model_reset();
            e = idle_exp();
        end
        q.push_back(e);
        if (reset) begin
            if (exec) m_count++;
            if (exec && opc == 6'b001000) m_phase = 3;
            else if (m_phase != 3)        m_phase = md ? 2 : 1;
            m_prev = rq;
        end
    endtask

    function automatic logic [5:0] rand_opc();
        logic [5:0] o;
        o = 6'($urandom_range(0, 63));
        if (o == 6'b001000) o = 6'b000000;
        return o;
    endfunction

    // Monitor: compare every expectation on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("decode", 32'({s_inc, s_inm, we3, wez, op, pc_en}), 32'(e.dec));
                check("halted", 32'(halted), 32'(e.hlt));
                check("instr_count", 32'(instr_count), 32'(e.c16));
                check("instr_count_w4", 32'(instr_count4), 32'(e.c4));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; opcode = '0; z = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        do_cycle(0, 6'b100000, 0, 0, 0, 0);
        do_cycle(0, 6'b100000, 0, 0, 0, 0);
        // Boot cycle, then first executing cycle
        do_cycle(1, 6'b100000, 0, 0, 0, 0);
        do_cycle(1, 6'b100000, 0, 0, 0, 0);
        // Directed jumps and load immediate
        do_cycle(1, 6'b000010, 1, 0, 0, 0);
        do_cycle(1, 6'b000010, 0, 0, 0, 0);
        do_cycle(1, 6'b000011, 1, 0, 0, 0);
        do_cycle(1, 6'b000011, 0, 0, 0, 0);
        do_cycle(1, 6'b000001, 0, 0, 0, 0);
        do_cycle(1, 6'b000001, 1, 0, 0, 0);
        do_cycle(1, 6'b000111, 1, 0, 0, 0);
        do_cycle(1, 6'b111100, 0, 0, 0, 0);
        // Random free run
        for (int i = 0; i < 60; i++) begin
            do_cycle(1, rand_opc(), 1'($urandom), 0, 1'($urandom), 0);
        end
        // Single step with a held request and a second pulse
        for (int i = 0; i < 3; i++)  do_cycle(1, 6'b100000, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)  do_cycle(1, 6'b100000, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++)  do_cycle(1, 6'b100100, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)  do_cycle(1, 6'b100100, 0, 1, 1, 0);
        // Random mode and step activity
        for (int i = 0; i < 80; i++) begin
            do_cycle(1, rand_opc(), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        // Halt from free run, then hold there under noise
        for (int i = 0; i < 3; i++)  do_cycle(1, 6'b100000, 0, 0, 0, 0);
        do_cycle(1, 6'b001000, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1, 6'(6'h20 + 6'($urandom_range(0, 31))), 1'($urandom),
                     1'($urandom), 1'(i), 0);
        end
        // Asynchronous reset out of halt
        do_cycle(1, 6'b100000, 0, 0, 0, 1);
        do_cycle(0, 6'b000000, 0, 0, 0, 0);
        // Saturation of the narrow counter with NOPs
        for (int i = 0; i < 22; i++) do_cycle(1, 6'b000000, 0, 0, 0, 0);
        // Halt via a stepped execution
        do_cycle(1, 6'b000000, 0, 1, 0, 0);
        do_cycle(1, 6'b001000, 0, 1, 0, 0);
        do_cycle(1, 6'b001000, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) do_cycle(1, 6'b100000, 0, 1, 1'(i), 0);
        // Mid-run reset during an ALU cycle
        do_cycle(0, 6'b100000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 6'b101000, 0, 0, 0, 0);
        do_cycle(1, 6'b101000, 0, 0, 0, 1);
        do_cycle(1, 6'b101000, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1, rand_opc(), 1'($urandom), 0, 0, 0);
        end
        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
